// File: rtl/fifo_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_loader_pkg : shared state encoding and default sizing for fifo_loader
// Revision: 1.0
// ---------------------------------------------------------------------------
package fifo_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_FIFO = 8;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_BITS     = 8;
  localparam int WORD_BITS    = DEF_DEPTH * DEF_BITS;
  localparam int DRAIN_CYCLES = DEF_DEPTH + DEF_NUM_FIFO - 1;

endpackage
`default_nettype wire

// File: rtl/fifo_loader_word_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// word_serializer : shifts a latched row word out one element per cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
module word_serializer
  import fifo_loader_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int BITS  = DEF_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DEPTH*BITS-1:0] data,
  output logic                  active,
  output logic [BITS-1:0]       elem,
  output logic                  last
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH*BITS-1:0] shreg;
  logic [CNT_W-1:0]      cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      shreg  <= data;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      shreg <= shreg >> BITS;
      if (last) begin
        cnt    <= '0;
        active <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Element 0 sits in the low slot, so it leaves first.
  assign elem = shreg[BITS-1:0];
  assign last = active && (cnt == CNT_W'(DEPTH - 1));

endmodule
`default_nettype wire

// File: rtl/fifo_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_loader : loads one row word per fifo, then drains with per-lane skew
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_loader
  import fifo_loader_pkg::*;
#(
  parameter int NUM_FIFO = DEF_NUM_FIFO,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int BITS     = DEF_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [DEPTH*BITS-1:0]    in_data,
  output logic                     in_ready,
  output logic [NUM_FIFO-1:0]      fifo_en,
  output logic [NUM_FIFO*BITS-1:0] fifo_d,
  output logic [NUM_FIFO-1:0]      lane_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int DRAIN_LEN = DEPTH + NUM_FIFO - 1;
  localparam int ROW_W     = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
  localparam int DRN_W     = $clog2(DEPTH + NUM_FIFO);

  state_t            state, state_nx;
  logic [ROW_W-1:0]  row;
  logic [DRN_W-1:0]  t;
  logic              ser_load, ser_active, ser_last;
  logic [BITS-1:0]   ser_elem;
  logic              last_row;
  logic              row_done;
  logic [NUM_FIFO-1:0] drain_win;

  word_serializer #(
    .DEPTH (DEPTH),
    .BITS  (BITS)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (ser_load),
    .data   (in_data),
    .active (ser_active),
    .elem   (ser_elem),
    .last   (ser_last)
  );

  assign in_ready = (state == LOAD) && !ser_active;
  assign ser_load = in_ready && in_valid;
  assign last_row = (row == ROW_W'(NUM_FIFO - 1));
  assign row_done = (state == LOAD) && ser_last;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Lane i is live for DEPTH drain cycles starting at t = i.
  for (genvar i = 0; i < NUM_FIFO; i++) begin : g_lane
    localparam logic [DRN_W-1:0] HI = DRN_W'(i + DEPTH);
    if (i == 0) begin : g_first
      assign drain_win[i] = (t < HI);
    end else begin : g_rest
      localparam logic [DRN_W-1:0] LO = DRN_W'(i);
      assign drain_win[i] = (t >= LO) && (t < HI);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      t   <= '0;
    end else begin
      case (state)
        LOAD:    if (row_done && !last_row) row <= row + 1'b1;
        DRAIN:   t <= t + 1'b1;
        DONE: begin
          row <= '0;
          t   <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    fifo_en    = '0;
    fifo_d     = '0;
    lane_valid = '0;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        if (row_done && last_row) state_nx = DRAIN;
        if (ser_active) begin
          for (int i = 0; i < NUM_FIFO; i++) begin
            if (row == ROW_W'(i)) begin
              fifo_en[i]             = 1'b1;
              fifo_d[i*BITS +: BITS] = ser_elem;
            end
          end
        end
      end
      DRAIN: begin
        // fifo_d stays zero so the bank is empty once the drain completes.
        fifo_en    = drain_win;
        lane_valid = drain_win;
        if (t == DRN_W'(DRAIN_LEN - 1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_loader : directed passes with random rows against fifo models
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fifo_loader;

  localparam int NF  = 8;
  localparam int DP  = 8;
  localparam int BW  = 8;
  localparam int DRN = DP + NF - 1;

  logic               clk = 1'b0;
  logic               rst, start, in_valid;
  logic [DP*BW-1:0]   in_data;
  logic               in_ready;
  logic [NF-1:0]      fifo_en;
  logic [NF*BW-1:0]   fifo_d;
  logic [NF-1:0]      lane_valid;
  logic               busy, done;

  fifo_loader #(.NUM_FIFO(NF), .DEPTH(DP), .BITS(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_en    (fifo_en),
    .fifo_d     (fifo_d),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Shift-register fifo bank: q is the oldest entry, fm[i][DP-1].
  logic [BW-1:0] fm [NF][DP];
  logic          fifo_clr;

  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (fifo_clr) begin
        for (int j = 0; j < DP; j++) fm[i][j] <= '0;
      end else if (fifo_en[i]) begin
        for (int j = DP - 1; j > 0; j--) fm[i][j] <= fm[i][j-1];
        fm[i][0] <= fifo_d[i*BW +: BW];
      end
    end
  end

  logic [DP*BW-1:0] rows [NF];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Lanes that should be live at drain cycle t.
  function automatic logic [NF-1:0] win(input int t);
    logic [NF-1:0] m = '0;
    for (int i = 0; i < NF; i++) m[i] = (t >= i) && (t < i + DP);
    return m;
  endfunction

  task automatic fill(input bit rnd);
    for (int r = 0; r < NF; r++)
      for (int k = 0; k < DP; k++)
        rows[r][k*BW +: BW] = rnd ? BW'($urandom) : BW'(8 * r + k);
  endtask

  task automatic fifo_reset();
    fifo_clr = 1'b1;
    cyc();
    fifo_clr = 1'b0;
  endtask

  task automatic begin_pass();
    in_valid = 1'b0;
    start    = 1'b1;
    neg();
    chk("idle_busy", busy, 0);
    cyc();
    start = 1'b0;
  endtask

  task automatic load_row(input int r, input int gap, input bit poke);
    logic [NF*BW-1:0] e;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      neg();
      chk("gap_en", fifo_en, 0);
      chk("gap_rdy", in_ready, 1);
      cyc();
    end
    in_valid = 1'b1;
    in_data  = rows[r];
    neg();
    chk("hs_rdy", in_ready, 1);
    chk("hs_busy", busy, 1);
    chk("hs_en", fifo_en, 0);
    cyc();
    in_data = ~rows[r];
    for (int k = 0; k < DP; k++) begin
      if (poke) start = k[0];
      e = '0;
      e[r*BW +: BW] = rows[r][k*BW +: BW];
      neg();
      chk("load_en", fifo_en, NF'(1) << r);
      chk("load_d", fifo_d, e);
      chk("load_rdy", in_ready, 0);
      chk("load_lv", lane_valid, 0);
      cyc();
    end
    start = 1'b0;
  endtask

  task automatic drain(input bit poke);
    logic [NF-1:0] w;
    for (int t = 0; t < DRN; t++) begin
      start    = poke & t[0];
      in_valid = poke;
      in_data  = {$urandom, $urandom};
      w = win(t);
      neg();
      chk("drn_lv", lane_valid, w);
      chk("drn_en", fifo_en, w);
      chk("drn_d", fifo_d, 0);
      chk("drn_rdy", in_ready, 0);
      chk("drn_done", done, 0);
      for (int i = 0; i < NF; i++)
        if (w[i]) chk("drn_q", fm[i][DP-1], rows[i][(t-i)*BW +: BW]);
      cyc();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    neg();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_en", fifo_en, 0);
    cyc();
    neg();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    for (int i = 0; i < NF; i++)
      for (int j = 0; j < DP; j++)
        chk("fifo_zero", fm[i][j], 0);
    cyc();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    fifo_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        rst      = 1'b0;
        fifo_clr = 1'b0;
      end
      neg();
      chk("rst_en", fifo_en, 0);
      chk("rst_d", fifo_d, 0);
      chk("rst_rdy", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lv", lane_valid, 0);
    end
    cyc();
    start    = 1'b0;
    in_valid = 1'b0;
    neg();
    chk("start_busy", busy, 1);
    chk("start_rdy", in_ready, 1);
    cyc();

    // Full pass, counting pattern, back-to-back words, start poked mid-load.
    fill(1'b0);
    for (int r = 0; r < NF; r++) load_row(r, 0, r == 2);
    drain(1'b0);

    // Random rows with gaps; start and in_valid toggled through the drain.
    fill(1'b1);
    begin_pass();
    for (int r = 0; r < NF; r++) load_row(r, 3, 1'b0);
    drain(1'b1);

    // Abort after three rows.
    fill(1'b1);
    begin_pass();
    for (int r = 0; r < 3; r++) load_row(r, int'($urandom_range(0, 2)), 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    cyc();
    rst = 1'b0;
    neg();
    chk("abort_busy", busy, 0);
    chk("abort_en", fifo_en, 0);
    chk("abort_rdy", in_ready, 0);
    chk("abort_done", done, 0);
    fifo_reset();

    fill(1'b0);
    begin_pass();
    for (int r = 0; r < NF; r++) load_row(r, 0, 1'b0);
    drain(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
